// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: FSM state encodings and the default baud divider,
// so the transmit and receive stages always agree on both.
package uart_tx_fifo_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned BIT_IDX_W        = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with show-ahead read data.
// Full/empty are derived from the occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ok    = wr_en && !full;
        rd_ok    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO. Outputs are registered from
// the current state, so the line lags the FSM by exactly one cycle.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BYTE_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]      shift_q, shift_d;
    logic                   serial_out_q, serial_out_d;
    logic                   busy_q, busy_d;
    logic                   tx_done_q, tx_done_d;
    logic                   cnt_last;
    logic                   pop;
    logic [BYTE_W-1:0]      fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid && in_ready),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready   = !fifo_full;
    assign serial_out = serial_out_q;
    assign busy       = busy_q;
    assign tx_done    = tx_done_q;

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        pop          = 1'b0;
        serial_out_d = 1'b1;
        busy_d       = (state_q != IDLE);
        tx_done_d    = 1'b0;
        cnt_last     = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = fifo_rd_data;
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                serial_out_d = 1'b0;
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                serial_out_d = shift_q[bit_idx_q];
                if (cnt_last) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == BIT_IDX_W'(7)) state_d = STOP;
                    else bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                serial_out_d = 1'b1;
                if (cnt_last) begin
                    tx_done_d = 1'b1;
                    clk_cnt_d = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            serial_out_q <= 1'b1;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            serial_out_q <= serial_out_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance at 16 clocks/bit, one at 2.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data, in_data2;
    logic       in_valid, in_valid2;
    logic       in_ready, serial_out, busy, tx_done;
    logic       in_ready2, serial_out2, busy2, tx_done2;
    logic [2:0] fifo_count, fifo_count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data2),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .serial_out (serial_out2),
        .busy       (busy2),
        .tx_done    (tx_done2),
        .fifo_count (fifo_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; a producer drops in_valid once its byte was taken.
    task automatic step(input int n);
        logic a1, a2;
        for (int i = 0; i < n; i++) begin
            a1 = in_valid && in_ready;
            a2 = in_valid2 && in_ready2;
            @(posedge clk);
            #1;
            if (a1 === 1'b1) in_valid = 1'b0;
            if (a2 === 1'b1) in_valid2 = 1'b0;
        end
    endtask

    // Called at (or pre cycles after) the edge where the start bit appears;
    // returns at the edge where the following frame would start.
    task automatic chk_frame(input logic [7:0] exp, input int pre, input string tag);
        logic [7:0] got;
        got = '0;
        step(8 - pre);
        chk({tag, "_start"}, 32'(serial_out), 32'd0);
        for (int b = 0; b < 8; b++) begin
            step(16);
            got[b] = serial_out;
        end
        chk({tag, "_data"}, 32'(got), 32'(exp));
        step(16);
        chk({tag, "_stop"}, 32'(serial_out), 32'd1);
        step(7);
        chk({tag, "_tx_done"}, 32'(tx_done), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy), 32'd1);
        step(1);
    endtask

    initial begin
        logic [9:0] f2;
        logic [7:0] r [4];
        logic [7:0] seq [4];
        int bad, pulses, bad_td, lows;

        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_data = '0; in_data2 = '0;
        step(3);
        rst = 1'b0;
        chk("rst_serial", 32'(serial_out), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_done", 32'(tx_done), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_serial", 32'(serial_out2), 32'd1);

        // Single byte A5 from idle: line low two edges after acceptance.
        in_data = 8'hA5; in_valid = 1'b1;
        step(1);
        chk("t1_e0_serial", 32'(serial_out), 32'd1);
        chk("t1_e0_count", 32'(fifo_count), 32'd1);
        step(1);
        chk("t1_e1_serial", 32'(serial_out), 32'd1);
        chk("t1_e1_busy", 32'(busy), 32'd0);
        chk("t1_e1_count", 32'(fifo_count), 32'd0);
        step(1);
        chk("t1_e2_serial", 32'(serial_out), 32'd0);
        chk("t1_e2_busy", 32'(busy), 32'd1);
        chk_frame(8'hA5, 0, "t1");
        chk("t1_e162_busy", 32'(busy), 32'd0);
        chk("t1_e162_tx_done", 32'(tx_done), 32'd0);
        chk("t1_e162_serial", 32'(serial_out), 32'd1);

        // Two clocks per bit: every cycle of the 20-cycle frame is checked.
        in_data2 = 8'h81; in_valid2 = 1'b1;
        step(3);
        chk("t6_busy_start", 32'(busy2), 32'd1);
        f2 = {1'b1, 8'h81, 1'b0};
        bad = 0; pulses = 0; bad_td = 0;
        for (int k = 0; k < 20; k++) begin
            if (serial_out2 !== f2[k / 2]) bad++;
            if (tx_done2 === 1'b1) begin
                pulses++;
                if (k != 19) bad_td++;
            end
            step(1);
        end
        chk("t6_bit_cycles", 32'(bad), 32'd0);
        chk("t6_tx_done_pulses", 32'(pulses), 32'd1);
        chk("t6_tx_done_pos", 32'(bad_td), 32'd0);
        chk("t6_end_serial", 32'(serial_out2), 32'd1);
        chk("t6_end_busy", 32'(busy2), 32'd0);

        // Fill the FIFO behind an in-flight 55, then hold 77 while full.
        in_data = 8'h55; in_valid = 1'b1;
        step(3);
        chk("t2_line_low", 32'(serial_out), 32'd0);
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C; seq[3] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            in_data = seq[i]; in_valid = 1'b1;
            step(1);
        end
        chk("t2_full_count", 32'(fifo_count), 32'd4);
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        in_data = 8'h77; in_valid = 1'b1;
        step(3);
        chk("t3_held_count", 32'(fifo_count), 32'd4);
        chk("t3_held_ready", 32'(in_ready), 32'd0);
        chk_frame(8'h55, 7, "f55");
        chk("t3_after_pop_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) chk_frame(seq[i], 0, $sformatf("f%02h", seq[i]));
        chk_frame(8'h77, 0, "f77");
        chk("t3_end_busy", 32'(busy), 32'd0);
        chk("t3_end_count", 32'(fifo_count), 32'd0);
        chk("t3_end_serial", 32'(serial_out), 32'd1);

        // Reset during data bit 3 of 5A with two bytes queued.
        in_data = 8'h5A; in_valid = 1'b1;
        step(1);
        in_data = 8'h11; in_valid = 1'b1;
        step(1);
        in_data = 8'h22; in_valid = 1'b1;
        step(1);
        step(70);
        chk("t4_bit3", 32'(serial_out), 32'd1);
        chk("t4_queued", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        step(1);
        chk("t4_rst_serial", 32'(serial_out), 32'd1);
        chk("t4_rst_count", 32'(fifo_count), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (serial_out !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("t4_no_frame", 32'(lows), 32'd0);

        // Random bytes, four per burst, checked frame by frame.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 4; i++) begin
                in_data = r[i]; in_valid = 1'b1;
                step(1);
            end
            chk_frame(r[0], 1, $sformatf("t5r%0d_0", round));
            for (int i = 1; i < 4; i++) chk_frame(r[i], 0, $sformatf("t5r%0d_%0d", round, i));
            chk($sformatf("t5r%0d_idle", round), 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
